key_filter: RTL



---
 rtl/key_filter.sv | 99 +++++++++
 1 files changed

// File: rtl/key_filter.sv
// key_filter: synchronises and debounces an active-low push button.
// Emits press/release pulses, a debounced level and a press-toggled blink enable.
module key_filter #(
    parameter int CNT_MAX = 999_999,
    parameter int CNT_W   = 20
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_flag,
    output logic key_release,
    output logic key_state,
    output logic blink_en
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_FILT   = 2'd1;
    localparam logic [1:0] DOWN         = 2'd2;
    localparam logic [1:0] RELEASE_FILT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic             key_s1;
    logic             key_sync;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; idles high so a released key reads as released.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1   <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_s1   <= key_in;
            key_sync <= key_s1;
        end
    end

    // Debounce FSM with hold counter; pulses default low every cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            key_state   <= 1'b0;
            blink_en    <= 1'b1;
        end else begin
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!key_sync) begin
                        state <= PRESS_FILT;
                        cnt   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (key_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= DOWN;
                        cnt       <= '0;
                        key_flag  <= 1'b1;
                        key_state <= 1'b1;
                        blink_en  <= ~blink_en;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (key_sync) begin
                        state <= RELEASE_FILT;
                        cnt   <= '0;
                    end
                end
                RELEASE_FILT: begin
                    if (!key_sync) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        key_release <= 1'b1;
                        key_state   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
